multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit core. Sequences the datapath per instruction through
//  fetch/decode/execute/memory/IO/writeback and emits one-cycle enables for IR, PC, register file
//  and memories. Handles memory-ready and IN/OUT handshakes, halt, pause-at-boundary, retire count.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting on imem_ready/dmem_ready before ERR; 0 = no timeout
//  CNT_W        16  width of instret retire counter
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  run          in   1      1 = execute; sampled in IDLE and in WB
//  inst         in   16     IR contents; valid from ID onward (op1=[15:14], op2=[13:11], op3=[7:4])
//  cond         in   1      branch condition from flags; sampled in EX only
//  imem_ready   in   1      instruction memory data valid
//  dmem_ready   in   1      data memory access complete
//  in_valid     in   1      external input word available
//  out_ready    in   1      external sink accepts output word
//  imem_re      out  1      instruction fetch request
//  ir_we        out  1      load IR from imem data
//  dmem_re      out  1      data memory read (LD)
//  dmem_we      out  1      data memory write (ST)
//  in_ready     out  1      core ready to take input word (IN)
//  out_valid    out  1      output word valid (OUT)
//  rf_we        out  1      register file write strobe
//  pc_we        out  1      PC update strobe
//  pc_src       out  1      0 = PC+1, 1 = branch target
//  retire       out  1      pulse: instruction completed
//  instret      out  CNT_W  retired-instruction count
//  state_o      out  4      current state code (debug)
//  halted       out  1      sticky: HLT executed
//  err          out  1      sticky: memory timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, all outputs 0, instret=0, wait counter=0, taken_q=0.
//  States/codes: IDLE0 IF1 ID2 EX3 MEM4 IO5 WB6 HALT7 ERR8. All outputs Moore except ir_we.
//  IDLE: outputs 0; run=1 -> IF.
//  IF: imem_re=1 held; imem_ready=1 -> ir_we=1 that cycle, -> ID.
//  ID: HLT (op1=11,op3=1111) -> HALT (no retire, no pc_we); else -> EX.
//  EX: taken_q <= (op1=10 & op2=100) | (op1=10 & op2=111 & cond). Next: op1=00/01 -> MEM;
//   op1=11 & op3=1100 or 1101 -> IO; else -> WB.
//  MEM: LD dmem_re=1 / ST dmem_we=1 held until dmem_ready=1 -> WB.
//  IO: IN: in_ready=1 until in_valid=1 (transfer cycle) -> WB; OUT: out_valid=1 until out_ready=1
//   -> WB. No timeout in IO; out_valid never drops before out_ready.
//  WB (1 cycle): pc_we=1, pc_src=taken_q, retire=1, instret+1 (wraps to 0 at 2^CNT_W);
//   rf_we=1 iff (op1=11 & op3<=1100 & op3!=0101) | op1=00 | (op1=10 & op2=000).
//   run=1 -> IF; run=0 -> IDLE (pause at instruction boundary, PC already updated).
//  Undefined encodings (op1=11 op3=1110; op1=10 op2 not 000/100/111): NOP, retire with pc+1.
//  Timeout: counter clears on entry to IF/MEM, +1 each cycle ready=0; reaching MEM_TIMEOUT
//   -> ERR. ERR/HALT: all strobes 0, sticky flag 1, exit only by reset; run ignored.
//  run deasserted mid-instruction has no effect until WB.
//  Latency with zero-wait memory: ALU/LI/B/CMP 4 cycles, LD/ST 5, IN/OUT >=5.
//  Reset mid-operation: immediate return to IDLE; pending dmem_we/out_valid drop asynchronously.
// TESTING
//  Reset, run=1, inst=0xC000 (ADD), ready=1 -> states 1,2,3,6; WB: rf_we=1,pc_we=1,pc_src=0; instret=1
//  inst=0x0000 (LD), dmem_ready low 3 cycles -> dmem_re held 4 cycles, then WB rf_we=1; 8 cycles total
//  inst=0xBF00 (BE) cond=1 -> pc_src=1 in WB, rf_we=0; cond=0 -> pc_src=0; 0xA000 (B) -> pc_src=1
//  inst=0xC0D0 (OUT), out_ready low 5 cycles -> out_valid stable 6 cycles, then WB rf_we=0
//  inst=0xC0F0 (HLT) -> HALT after ID, halted=1, instret unchanged, no further strobes with run=1
//  MEM_TIMEOUT=4, imem_ready=0 -> ERR after 4 IF cycles, err=1; rst_n pulse -> IDLE, err=0

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the 16-bit core. Each instruction walks
//   IF -> ID -> EX -> [MEM | IO] -> WB. The FSM issues one-cycle enables for
//   the IR, PC, register file and memories. It also handles the memory-ready
//   and IN/OUT handshakes, halt, pausing at an instruction boundary, and the
//   retired-instruction count.
//
// Parameters
//   MEM_TIMEOUT  cycles allowed waiting on imem_ready/dmem_ready before ERR
//                (0 disables the timeout)
//   CNT_W        width of the instret counter
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   run                       execute enable, sampled in IDLE and WB only
//   inst[15:0]                IR contents (op1=[15:14] op2=[13:11] op3=[7:4])
//   cond                      branch condition, sampled in EX
//   imem_ready, dmem_ready    memory handshakes
//   in_valid, out_ready       IN / OUT handshakes
//   imem_re, ir_we            fetch request, IR load (ir_we is Mealy)
//   dmem_re, dmem_we          LD / ST strobes, held until dmem_ready
//   in_ready, out_valid       IN / OUT handshake outputs
//   rf_we, pc_we, pc_src      writeback strobes (pc_src 1 = branch target)
//   retire, instret           retire pulse and retired count
//   state_o                   current state code
//   halted, err               sticky HALT / timeout indications
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      inst,
  input  logic             cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             imem_re,
  output logic             ir_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             in_ready,
  output logic             out_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o,
  output logic             halted,
  output logic             err
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_IF   = 4'd1;
  localparam logic [3:0] S_ID   = 4'd2;
  localparam logic [3:0] S_EX   = 4'd3;
  localparam logic [3:0] S_MEM  = 4'd4;
  localparam logic [3:0] S_IO   = 4'd5;
  localparam logic [3:0] S_WB   = 4'd6;
  localparam logic [3:0] S_HALT = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  // The wait counter only has to reach MEM_TIMEOUT-1. The FSM leaves for ERR
  // on the cycle it would reach MEM_TIMEOUT.
  localparam int             WCW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit             TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [WCW-1:0] TO_LIM = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]     state, state_nx;
  logic [WCW-1:0] wait_cnt;
  logic           taken_q;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [1:0] op1;
  logic [2:0] op2;
  logic [3:0] op3;
  logic       is_ld, is_st, is_in, is_out, is_hlt;
  logic       br_always, br_cond, wb_rf;
  logic       unused_bits;

  assign op1 = inst[15:14];
  assign op2 = inst[13:11];
  assign op3 = inst[7:4];

  assign is_ld     = (op1 == 2'b00);
  assign is_st     = (op1 == 2'b01);
  assign is_in     = (op1 == 2'b11) && (op3 == 4'b1100);
  assign is_out    = (op1 == 2'b11) && (op3 == 4'b1101);
  assign is_hlt    = (op1 == 2'b11) && (op3 == 4'b1111);
  assign br_always = (op1 == 2'b10) && (op2 == 3'b100);
  assign br_cond   = (op1 == 2'b10) && (op2 == 3'b111);

  // The register file is written by the ALU/IN group (op3 up to 1100, except
  // 0101, which is CMP), by LD, and by LI. Undefined encodings fall outside
  // every term. They retire as a NOP with PC+1.
  assign wb_rf = ((op1 == 2'b11) && (op3 <= 4'b1100) && (op3 != 4'b0101)) ||
                 (op1 == 2'b00) ||
                 ((op1 == 2'b10) && (op2 == 3'b000));

  // Operand fields belong to the datapath. The sequencer does not look at them.
  assign unused_bits = ^{inst[10:8], inst[3:0]};

  // ---------------------------------------------------------------------------
  // Memory wait timeout
  // ---------------------------------------------------------------------------
  logic mem_wait, wait_hit;

  assign mem_wait = ((state == S_IF)  && !imem_ready) ||
                    ((state == S_MEM) && !dmem_ready);
  assign wait_hit = TO_EN && (wait_cnt == TO_LIM);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = S_IF;
      S_IF: begin
        if (imem_ready)    state_nx = S_ID;
        else if (wait_hit) state_nx = S_ERR;
      end
      S_ID:   state_nx = is_hlt ? S_HALT : S_EX;
      S_EX: begin
        if (is_ld || is_st)      state_nx = S_MEM;
        else if (is_in || is_out) state_nx = S_IO;
        else                      state_nx = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)    state_nx = S_WB;
        else if (wait_hit) state_nx = S_ERR;
      end
      // No timeout here. The external side may stall IN/OUT indefinitely.
      S_IO: begin
        if (is_in  && in_valid)  state_nx = S_WB;
        if (is_out && out_ready) state_nx = S_WB;
      end
      S_WB:   state_nx = run ? S_IF : S_IDLE;
      S_HALT: state_nx = S_HALT;
      S_ERR:  state_nx = S_ERR;
      default: state_nx = S_ERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, wait counter, branch latch, retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The wait counter restarts on every entry to a memory-wait state. This
  // covers WB -> IF, where the previous fetch's count must not carry over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state_nx != state) && ((state_nx == S_IF) || (state_nx == S_MEM))) begin
      wait_cnt <= '0;
    end else if (mem_wait) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // cond is only meaningful in EX. Latch the decision here so that WB does not
  // depend on the flags still being stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q <= 1'b0;
    end else if (state == S_EX) begin
      taken_q <= br_always || (br_cond && cond);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (state == S_WB) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register, so reset clears them at once.
  // ir_we is the only output that depends directly on an input.
  // ---------------------------------------------------------------------------
  assign imem_re   = (state == S_IF);
  assign ir_we     = (state == S_IF) && imem_ready;
  assign dmem_re   = (state == S_MEM) && is_ld;
  assign dmem_we   = (state == S_MEM) && is_st;
  assign in_ready  = (state == S_IO) && is_in;
  assign out_valid = (state == S_IO) && is_out;
  assign rf_we     = (state == S_WB) && wb_rf;
  assign pc_we     = (state == S_WB);
  assign pc_src    = (state == S_WB) && taken_q;
  assign retire    = (state == S_WB);
  assign state_o   = state;
  assign halted    = (state == S_HALT);
  assign err       = (state == S_ERR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  logic             clk, rst_n, run, cond;
  logic [15:0]      inst;
  logic             imem_ready, dmem_ready, in_valid, out_ready;
  logic             imem_re, ir_we, dmem_re, dmem_we, in_ready, out_valid;
  logic             rf_we, pc_we, pc_src, retire, halted, err;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .inst(inst), .cond(cond),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .in_valid(in_valid), .out_ready(out_ready),
    .imem_re(imem_re), .ir_we(ir_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .in_ready(in_ready), .out_valid(out_valid), .rf_we(rf_we), .pc_we(pc_we),
    .pc_src(pc_src), .retire(retire), .instret(instret), .state_o(state_o),
    .halted(halted), .err(err)
  );

  // {imem_re, ir_we, dmem_re, dmem_we, in_ready, out_valid, rf_we, pc_we, pc_src, retire}
  logic [9:0] strb;
  assign strb = {imem_re, ir_we, dmem_re, dmem_we, in_ready, out_valid,
                 rf_we, pc_we, pc_src, retire};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; inst = 16'h0000; cond = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_flags", 32'({halted, err}), 32'd0);

    // ADD: IF ID EX WB
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; inst = 16'hC000; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick; chk("add_if", 32'(state_o), 32'd1); chk("add_if_strb", 32'(strb), 32'b1100000000);
    tick; chk("add_id", 32'(state_o), 32'd2); chk("add_id_strb", 32'(strb), 32'd0);
    tick; chk("add_ex", 32'(state_o), 32'd3); chk("add_ex_strb", 32'(strb), 32'd0);
    tick; chk("add_wb", 32'(state_o), 32'd6); chk("add_wb_strb", 32'(strb), 32'b0000001101);
    chk("add_wb_instret", 32'(instret), 32'd0);
    tick; chk("add_next_if", 32'(state_o), 32'd1); chk("add_instret", 32'(instret), 32'd1);

    // LD with three dmem wait cycles: 8 cycles, dmem_re for 4
    inst = 16'h0000; dmem_ready = 1'b0;
    tick; tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("ld_mem_state", 32'(state_o), 32'd4);
      chk("ld_mem_strb", 32'(strb), 32'b0010000000);
    end
    dmem_ready = 1'b1;
    tick; chk("ld_wb", 32'(state_o), 32'd6); chk("ld_wb_strb", 32'(strb), 32'b0000001101);
    tick; chk("ld_next_if", 32'(state_o), 32'd1); chk("ld_instret", 32'(instret), 32'd2);

    // BE taken, BE not taken, B
    inst = 16'hBF00; cond = 1'b1;
    tick; tick; tick; chk("be_t_wb", 32'(strb), 32'b0000000111);
    tick; cond = 1'b0;
    tick; tick; tick; chk("be_nt_wb", 32'(strb), 32'b0000000101);
    tick; inst = 16'hA000;
    tick; tick; tick; chk("b_wb", 32'(strb), 32'b0000000111);
    tick; chk("br_instret", 32'(instret), 32'd5);

    // OUT with out_ready low for 5 cycles: out_valid held 6 cycles
    inst = 16'hC0D0; out_ready = 1'b0;
    tick; tick;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("out_io_state", 32'(state_o), 32'd5);
      chk("out_io_strb", 32'(strb), 32'b0000010000);
    end
    out_ready = 1'b1;
    tick; chk("out_wb", 32'(state_o), 32'd6); chk("out_wb_strb", 32'(strb), 32'b0000000101);
    tick; out_ready = 1'b0;

    // IN, input already valid: one IO cycle and a register write
    inst = 16'hC0C0; in_valid = 1'b1;
    tick; tick; tick; chk("in_io_strb", 32'(strb), 32'b0000100000);
    tick; chk("in_wb_strb", 32'(strb), 32'b0000001101);
    tick; in_valid = 1'b0; chk("in_instret", 32'(instret), 32'd7);

    // ST, then pause at the boundary with run=0 during WB
    inst = 16'h4000;
    tick; tick; tick; chk("st_mem_strb", 32'(strb), 32'b0001000000);
    tick; chk("st_wb_strb", 32'(strb), 32'b0000000101);
    run = 1'b0;
    tick; chk("pause_idle", 32'(state_o), 32'd0); chk("pause_strb", 32'(strb), 32'd0);
    chk("pause_instret", 32'(instret), 32'd8);
    tick; chk("pause_hold", 32'(state_o), 32'd0);
    run = 1'b1;
    tick; chk("resume_if", 32'(state_o), 32'd1);

    // Undefined encoding retires as NOP; 8 more retires wrap the 4-bit counter
    inst = 16'h8800;
    for (int i = 0; i < 8; i++) begin
      tick; tick; tick;
      chk("nop_wb_strb", 32'(strb), 32'b0000000101);
      tick;
    end
    chk("instret_wrap", 32'(instret), 32'd0);

    // HLT
    inst = 16'hC0F0;
    tick; tick;
    chk("hlt_state", 32'(state_o), 32'd7); chk("hlt_flag", 32'(halted), 32'd1);
    chk("hlt_strb", 32'(strb), 32'd0);
    tick; tick; tick;
    chk("hlt_stay", 32'(state_o), 32'd7); chk("hlt_stay_strb", 32'(strb), 32'd0);
    chk("hlt_instret", 32'(instret), 32'd0);

    // Reset out of HALT, then fetch timeout
    #2 rst_n = 1'b0;
    #1 chk("rst2_state", 32'(state_o), 32'd0); chk("rst2_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0; run = 1'b1;
    tick; chk("to_if1_strb", 32'(strb), 32'b1000000000);
    for (int k = 0; k < 3; k++) begin
      tick; chk("to_if_state", 32'(state_o), 32'd1);
    end
    tick; chk("to_err_state", 32'(state_o), 32'd8); chk("to_err_flag", 32'(err), 32'd1);
    chk("to_err_strb", 32'(strb), 32'd0);
    tick; chk("to_err_stay", 32'(state_o), 32'd8);
    #2 rst_n = 1'b0;
    #1 chk("rst3_state", 32'(state_o), 32'd0); chk("rst3_err", 32'(err), 32'd0);

    // Reset during OUT: out_valid drops without a clock edge
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1; inst = 16'hC0D0; out_ready = 1'b0;
    tick; tick; tick; tick;
    chk("async_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_strb", 32'(strb), 32'd0); chk("async_state", 32'(state_o), 32'd0);
    #1 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
